// File: rtl/mistral_mlab_delay_if.sv
// Data-side bundle for the MLAB delay line: enable, delay select,
// write data, sync-load controls and the registered Q/FILLED outputs.
interface mistral_mlab_delay_if #(
    parameter int WIDTH = 20
);
    localparam int AW = 5;

    logic             ENA;
    logic [AW-1:0]    LEN;
    logic [WIDTH-1:0] DATAIN;
    logic             SLOAD;
    logic [WIDTH-1:0] SDATA;
    logic [WIDTH-1:0] Q;
    logic             FILLED;

    modport master (
        output ENA, LEN, DATAIN, SLOAD, SDATA,
        input  Q, FILLED
    );

    modport slave (
        input  ENA, LEN, DATAIN, SLOAD, SDATA,
        output Q, FILLED
    );
endinterface

// File: rtl/mistral_mlab_delay.sv
// MLAB-backed programmable delay line (LEN+1 enabled edges, input to Q)
// followed by one output register with enable and sync-load behaviour.
// A saturating fill count keeps stale buffer contents from ever reaching Q
// after a reset, so the buffer itself never needs clearing.
module mistral_mlab_delay #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 32
) (
    input logic                 CLK,
    input logic                 SCLR,
    mistral_mlab_delay_if.slave bus
);
    localparam int AW = 5;

    if (DEPTH != 32) begin : g_bad_depth
        $error("mistral_mlab_delay: DEPTH must be 32");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             filled_q, filled_d;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rd_data;

    // Fill count saturates once every entry has been written at least once.
    function automatic logic [AW:0] sat_fill(input logic [AW:0] f);
        return (f == (AW+1)'(DEPTH)) ? f : f + (AW+1)'(1);
    endfunction

    // Read address trails the write pointer by LEN, wrapping modulo 32.
    assign raddr   = wptr_q - bus.LEN;
    assign rd_data = mem_q[raddr];

    // Buffer write: every enabled edge, including sync-load edges; reset leaves contents alone.
    always_ff @(posedge CLK) begin
        if (!SCLR && bus.ENA) begin
            mem_q[wptr_q] <= bus.DATAIN;
        end
    end

    // Next-state for pointer, fill count and output register; SLOAD beats LEN=0 beats buffered read.
    always_comb begin
        wptr_d   = wptr_q;
        fill_d   = fill_q;
        q_d      = q_q;
        filled_d = filled_q;
        if (bus.ENA) begin
            wptr_d = wptr_q + AW'(1);
            fill_d = sat_fill(fill_q);
            if (bus.SLOAD) begin
                q_d      = bus.SDATA;
                filled_d = 1'b1;
            end else if (bus.LEN == '0) begin
                q_d      = bus.DATAIN;
                filled_d = 1'b1;
            end else if (fill_q >= {1'b0, bus.LEN}) begin
                q_d      = rd_data;
                filled_d = 1'b1;
            end else begin
                q_d      = '0;
                filled_d = 1'b0;
            end
        end
    end

    // State registers; synchronous reset clears pointer, fill and outputs.
    always_ff @(posedge CLK) begin
        if (SCLR) begin
            wptr_q   <= '0;
            fill_q   <= '0;
            q_q      <= '0;
            filled_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            fill_q   <= fill_d;
            q_q      <= q_d;
            filled_q <= filled_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.FILLED = filled_q;
endmodule

// File: tb/tb_mistral_mlab_delay.sv
// Directed scoreboard bench for mistral_mlab_delay: stimulus pushes the
// hand-derived Q/FILLED expected after each edge; a monitor pops one entry
// per edge and compares.
module tb_mistral_mlab_delay;
    logic CLK;
    logic SCLR;

    mistral_mlab_delay_if #(.WIDTH(20)) bus ();

    mistral_mlab_delay #(.WIDTH(20), .DEPTH(32)) dut (
        .CLK  (CLK),
        .SCLR (SCLR),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        chk;
        logic [19:0] q;
        logic        f;
        string       nm;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Drive one edge's inputs at the falling edge and queue its expected result.
    task automatic step(input logic sclr, input logic ena, input logic [4:0] len,
                        input logic [19:0] din, input logic sload, input logic [19:0] sdata,
                        input logic chk, input logic [19:0] eq, input logic ef, input string nm);
        exp_t e;
        @(negedge CLK);
        SCLR       = sclr;
        bus.ENA    = ena;
        bus.LEN    = len;
        bus.DATAIN = din;
        bus.SLOAD  = sload;
        bus.SDATA  = sdata;
        e.chk = chk;
        e.q   = eq;
        e.f   = ef;
        e.nm  = nm;
        expq.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 20'h0, 1'b0, 20'h0, 1'b1, 20'h0, 1'b0, "reset");
    endtask

    // Monitor: one scoreboard entry per clock edge, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                if (e.chk) begin
                    n_vec++;
                    if (bus.Q !== e.q || bus.FILLED !== e.f) begin
                        n_err++;
                        $display("FAIL %s: Q=%h FILLED=%b, expected Q=%h FILLED=%b",
                                 e.nm, bus.Q, bus.FILLED, e.q, e.f);
                    end
                end
            end
        end
    end

    initial begin
        SCLR       = 1'b0;
        bus.ENA    = 1'b0;
        bus.LEN    = 5'd0;
        bus.DATAIN = 20'h0;
        bus.SLOAD  = 1'b0;
        bus.SDATA  = 20'h0;

        // Reset then stream at LEN=3: zeros for three edges, then 1,2,3,...
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 5'd3, 20'(k), 1'b0, 20'h0, 1'b1,
                 (k >= 4) ? 20'(k - 3) : 20'h0, (k >= 4), "len3_stream");
        end

        // LEN=31 stream of 0..99: first datum 0 at edge 32, 68 at edge 100.
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            step(1'b0, 1'b1, 5'd31, 20'(k - 1), 1'b0, 20'h0, 1'b1,
                 (k >= 32) ? 20'(k - 32) : 20'h0, (k >= 32), "len31_wrap");
        end

        // ENA gaps at LEN=2: disabled edges hold Q and do not count.
        do_reset();
        step(1'b0, 1'b1, 5'd2, 20'd10, 1'b0, 20'h0, 1'b1, 20'd0,  1'b0, "gap_en1");
        step(1'b0, 1'b0, 5'd2, 20'd99, 1'b0, 20'h0, 1'b1, 20'd0,  1'b0, "gap_dis1");
        step(1'b0, 1'b0, 5'd2, 20'd98, 1'b0, 20'h0, 1'b1, 20'd0,  1'b0, "gap_dis2");
        step(1'b0, 1'b1, 5'd2, 20'd20, 1'b0, 20'h0, 1'b1, 20'd0,  1'b0, "gap_en2");
        step(1'b0, 1'b1, 5'd2, 20'd30, 1'b0, 20'h0, 1'b1, 20'd10, 1'b1, "gap_en3");

        // Sync load mid-stream at LEN=1; the line keeps advancing underneath.
        do_reset();
        step(1'b0, 1'b1, 5'd1, 20'd5, 1'b0, 20'h0,     1'b1, 20'd0,     1'b0, "sload_pre0");
        step(1'b0, 1'b1, 5'd1, 20'd6, 1'b0, 20'h0,     1'b1, 20'd5,     1'b1, "sload_pre1");
        step(1'b0, 1'b1, 5'd1, 20'd7, 1'b1, 20'hABCDE, 1'b1, 20'hABCDE, 1'b1, "sload_edge");
        step(1'b0, 1'b1, 5'd1, 20'd8, 1'b0, 20'h0,     1'b1, 20'd7,     1'b1, "sload_after");

        // 40 writes at LEN=4, then reset with ENA low: stale data never reappears.
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b1, 5'd4, 20'(100 + k - 1), 1'b0, 20'h0, (k == 40),
                 20'd135, 1'b1, "len4_fill40");
        end
        step(1'b1, 1'b0, 5'd4, 20'h0, 1'b0, 20'h0, 1'b1, 20'd0, 1'b0, "sclr_ena0");
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 5'd4, 20'(200 + k - 1), 1'b0, 20'h0, 1'b1,
                 (k == 5) ? 20'd200 : 20'd0, (k == 5), "post_sclr");
        end

        // LEN changes after 1..10 at LEN=2, then a LEN=0 pass-through.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 5'd2, 20'(k), 1'b0, 20'h0, (k == 10), 20'd8, 1'b1, "len2_pre");
        end
        step(1'b0, 1'b1, 5'd8,  20'd11,     1'b0, 20'h0, 1'b1, 20'd3,      1'b1, "len_to8");
        step(1'b0, 1'b1, 5'd20, 20'd12,     1'b0, 20'h0, 1'b1, 20'd0,      1'b0, "len_to20");
        step(1'b0, 1'b0, 5'd0,  20'hFFFFF,  1'b0, 20'h0, 1'b1, 20'd0,      1'b0, "len0_dis");
        step(1'b0, 1'b1, 5'd0,  20'h12345,  1'b0, 20'h0, 1'b1, 20'h12345,  1'b1, "len0_pass");

        repeat (2) @(posedge CLK);
        #2;
        if (expq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
